axis_m_fifo: RTL and testbench
==============================

AXIS_M_FIFO -- requirements
Module: axis_m_fifo

Interface
REQ-001 Parameter DATA_W, default 8, width of din and m_axis_tdata.
REQ-002 Parameter DEPTH, default 8, FIFO entries; power of two, >= 2.
REQ-003 Parameter PKT_MODE, default 0; 0 = cut-through, 1 = store-and-forward by packet.
REQ-004 m_axis_aclk  in  1  single clock; all logic on its rising edge.
REQ-005 m_axis_areset  in  1  asynchronous, active-high reset.
REQ-006 newd  in  1  write request for one beat.
REQ-007 din  in  DATA_W  beat data.
REQ-008 din_last  in  1  beat is the final beat of its packet.
REQ-009 full  out  1  FIFO holds DEPTH beats.
REQ-010 level  out  $clog2(DEPTH)+1  beats currently stored.
REQ-011 ovf  out  1  sticky flag: a write was dropped.
REQ-012 pkt_cnt  out  16  count of tlast handshakes, wraps 0xFFFF -> 0.
REQ-013 m_axis_tdata  out  DATA_W  head beat data.
REQ-014 m_axis_tlast  out  1  head beat last flag.
REQ-015 m_axis_tvalid  out  1  head beat offered.
REQ-016 m_axis_tready  in  1  sink accepts.

Function
REQ-017 Storage SHALL be a DEPTH-entry circular buffer of {din_last, din}, with write and read pointers wrapping DEPTH-1 -> 0.
REQ-018 Write: newd=1 and full=0 at a clock edge SHALL store one beat and advance the write pointer.
REQ-019 newd=1 with full=1 SHALL drop the beat, leave FIFO state unchanged, and set ovf; full is evaluated before any same-cycle pop, so a pop does not make room for a same-cycle write.
REQ-020 Pop SHALL occur on an edge where m_axis_tvalid=1 and m_axis_tready=1; it advances the read pointer.
REQ-021 m_axis_tdata/m_axis_tlast SHALL present the head entry and remain stable while tvalid=1 and no pop occurs.
REQ-022 Once asserted, m_axis_tvalid SHALL stay high until the pop of that beat.
REQ-023 Cut-through (PKT_MODE=0): tvalid = (level != 0).
REQ-024 Packet mode (PKT_MODE=1): an internal counter last_cnt SHALL count stored beats with last=1 (+1 on write with din_last, -1 on pop with tlast, unchanged when both occur); tvalid = (level != 0) and (last_cnt != 0 or full).
REQ-025 The full term in REQ-024 SHALL prevent deadlock when a packet exceeds DEPTH; such a packet streams cut-through.
REQ-026 Latency: beat written into an empty FIFO at edge N SHALL first show tvalid=1 after edge N; never combinationally from newd. In packet mode this applies to the din_last beat of the packet.
REQ-027 level: +1 on write, -1 on pop, unchanged on simultaneous write and pop; full = (level == DEPTH).
REQ-028 Simultaneous write and pop with 0 < level < DEPTH SHALL both succeed.
REQ-029 Write into empty FIFO in the same cycle as tready=1 SHALL NOT pop (tvalid was 0).
REQ-030 pkt_cnt SHALL increment on each pop with m_axis_tlast=1.

Reset
REQ-031 m_axis_areset=1 SHALL asynchronously clear pointers, level, last_cnt, pkt_cnt and ovf, forcing m_axis_tvalid=0, full=0, level=0, ovf=0, pkt_cnt=0.
REQ-032 m_axis_tdata and m_axis_tlast SHALL be 0 after reset (storage cleared).
REQ-033 Reset asserted mid-packet SHALL discard all stored beats; the first write after release starts a new packet.
REQ-034 After reset release, the first write SHALL be accepted on the first rising edge with m_axis_areset=0.

Verification
REQ-035 Cut-through, tready=1, write 0x11,0x22,0x33(last) on consecutive edges -> beats appear one cycle later in order, tlast on 0x33, pkt_cnt=1.
REQ-036 Packet mode, write 0xA0..0xA3 with last on 0xA3 -> tvalid stays 0 until the edge storing 0xA3, then four beats stream and pkt_cnt=1.
REQ-037 DEPTH=8, tready=0, 9 writes -> full=1 after 8th, 9th dropped, ovf=1, level=8; then tready=1 -> exactly 8 beats pop in order.
REQ-038 Packet mode, DEPTH=8, 10-beat packet with tready=1 -> tvalid rises when full, all 10 beats delivered, no deadlock.
REQ-039 tready toggled 1,0,1,0 while streaming -> tdata/tlast held stable during each tready=0 cycle, no beat lost or duplicated.
REQ-040 Reset pulse after 2 of 4 beats written -> tvalid=0, level=0, pkt_cnt=0 immediately; a following 1-beat packet 0x5A(last) is delivered alone.

Source files
------------

// File: rtl/axis_m_fifo.sv
// axis_m_fifo: AXI-Stream master FIFO, cut-through or packet store-and-forward.
// Head beat is presented straight from storage; tvalid depends only on registered state.
module axis_m_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter bit PKT_MODE = 1'b0
) (
  input  logic                     m_axis_aclk,
  input  logic                     m_axis_areset,
  input  logic                     newd,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_last,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic [15:0]              pkt_cnt,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     level_q, level_d, cnt_q, cnt_d;
  logic            ovf_q;
  logic [15:0]     pkt_q;
  logic            wr, pop;
  assign full          = level_q == (AW+1)'(DEPTH);
  // the full term lets a packet longer than the FIFO stream through
  assign m_axis_tvalid = (level_q != '0) && (!PKT_MODE || cnt_q != '0 || full);
  assign {m_axis_tlast, m_axis_tdata} = mem_q[rd_q];
  assign wr      = newd && !full;
  assign pop     = m_axis_tvalid && m_axis_tready;
  assign level_d = level_q + (AW+1)'(wr) - (AW+1)'(pop);
  assign cnt_d   = cnt_q + (AW+1)'(wr && din_last) - (AW+1)'(pop && m_axis_tlast);
  assign level   = level_q;
  assign ovf     = ovf_q;
  assign pkt_cnt = pkt_q;
  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      pkt_q   <= '0;
    end else begin
      if (wr) mem_q[wr_q] <= {din_last, din};
      wr_q    <= wr_q + AW'(wr);
      rd_q    <= rd_q + AW'(pop);
      level_q <= level_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_q | (newd && full);
      pkt_q   <= pkt_q + 16'(pop && m_axis_tlast);
    end
  end
endmodule

// File: tb/tb_axis_m_fifo.sv
// tb_axis_m_fifo: scoreboard and vector checks of both FIFO modes.
module tb_axis_m_fifo;
  localparam int DEPTH = 8;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       newd [2];
  logic [7:0] din [2];
  logic       din_last [2];
  logic       tready [2];
  logic       full [2];
  logic [3:0] level [2];
  logic       ovf [2];
  logic [15:0] pkt_cnt [2];
  logic [7:0] tdata [2];
  logic       tlast [2];
  logic       tvalid [2];
  int checks = 0;
  int failures = 0;
  logic [8:0] sb [$];
  int  mcnt, mpk;
  bit  movf;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    axis_m_fifo #(.DATA_W(8), .DEPTH(DEPTH), .PKT_MODE(g[0])) dut (
      .m_axis_aclk(clk), .m_axis_areset(rst), .newd(newd[g]), .din(din[g]),
      .din_last(din_last[g]), .full(full[g]), .level(level[g]), .ovf(ovf[g]),
      .pkt_cnt(pkt_cnt[g]), .m_axis_tdata(tdata[g]), .m_axis_tlast(tlast[g]),
      .m_axis_tvalid(tvalid[g]), .m_axis_tready(tready[g]));
  end
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask
  function automatic bit mvalid(input int m);
    return sb.size() != 0 && (m == 0 || mcnt != 0 || sb.size() == DEPTH);
  endfunction
  task automatic cyc(input int m, input bit nd, input logic [7:0] d, input bit l, input bit r);
    bit fb, v;
    newd[m] = nd; din[m] = d; din_last[m] = l; tready[m] = r;
    fb = sb.size() == DEPTH;
    v  = mvalid(m);
    chk("tvalid", int'(tvalid[m]), int'(v));
    chk("level", int'(level[m]), sb.size());
    chk("full", int'(full[m]), int'(fb));
    chk("ovf", int'(ovf[m]), int'(movf));
    chk("pkt_cnt", int'(pkt_cnt[m]), mpk);
    if (v) begin
      chk("tdata", int'(tdata[m]), int'(sb[0][7:0]));
      chk("tlast", int'(tlast[m]), int'(sb[0][8]));
    end
    if (v && r) begin
      if (sb[0][8]) begin mcnt--; mpk = (mpk + 1) & 16'hFFFF; end
      void'(sb.pop_front());
    end
    if (nd && fb) movf = 1'b1;
    if (nd && !fb) begin
      sb.push_back({l, d});
      if (l) mcnt++;
    end
    @(posedge clk); #1;
  endtask
  task automatic do_rst();
    rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst tvalid", int'(tvalid[m]), 0);
      chk("rst level", int'(level[m]), 0);
      chk("rst full", int'(full[m]), 0);
      chk("rst ovf", int'(ovf[m]), 0);
      chk("rst pkt_cnt", int'(pkt_cnt[m]), 0);
      chk("rst tdata", int'(tdata[m]), 0);
      chk("rst tlast", int'(tlast[m]), 0);
      newd[m] = 1'b0; din[m] = '0; din_last[m] = 1'b0; tready[m] = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete(); mcnt = 0; mpk = 0; movf = 1'b0;
  endtask
  typedef struct {
    bit nd; logic [7:0] d; bit l; bit r;
    bit ev; logic [7:0] ed; bit el; int lvl; int pk;
  } vec_t;
  vec_t tbl [4];
  initial begin
    int wcount;
    tbl[0] = '{1, 8'h11, 0, 1, 1, 8'h11, 0, 1, 0};
    tbl[1] = '{1, 8'h22, 0, 1, 1, 8'h22, 0, 1, 0};
    tbl[2] = '{1, 8'h33, 1, 1, 1, 8'h33, 1, 1, 0};
    tbl[3] = '{0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1};
    for (int m = 0; m < 2; m++) begin
      newd[m] = 1'b0; din[m] = '0; din_last[m] = 1'b0; tready[m] = 1'b0;
    end
    @(posedge clk); #1;
    do_rst();
    for (int i = 0; i < 4; i++) begin
      cyc(0, tbl[i].nd, tbl[i].d, tbl[i].l, tbl[i].r);
      chk($sformatf("vec%0d tvalid", i), int'(tvalid[0]), int'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d tdata", i), int'(tdata[0]), int'(tbl[i].ed));
        chk($sformatf("vec%0d tlast", i), int'(tlast[0]), int'(tbl[i].el));
      end
      chk($sformatf("vec%0d level", i), int'(level[0]), tbl[i].lvl);
      chk($sformatf("vec%0d pkt_cnt", i), int'(pkt_cnt[0]), tbl[i].pk);
    end
    do_rst();
    for (int i = 0; i < 9; i++) cyc(0, 1, 8'(8'h40 + i), i == 7, 0);
    chk("ovf after 9", int'(ovf[0]), 1);
    chk("full after 9", int'(full[0]), 1);
    chk("level after 9", int'(level[0]), 8);
    for (int i = 0; i < 9; i++) cyc(0, 0, 8'h00, 0, 1);
    chk("drain level", int'(level[0]), 0);
    chk("drain pkt_cnt", int'(pkt_cnt[0]), 1);
    chk("ovf sticky", int'(ovf[0]), 1);
    do_rst();
    for (int i = 0; i < 12; i++) cyc(0, i < 4, 8'(8'hC0 + i), i == 3, i % 2 == 0);
    chk("toggle pkt_cnt", int'(pkt_cnt[0]), 1);
    do_rst();
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'(8'hA0 + i), i == 3, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'h00, 0, 1);
    chk("pkt36 pkt_cnt", int'(pkt_cnt[1]), 1);
    do_rst();
    wcount = 0;
    for (int k = 0; k < 100 && (wcount < 10 || sb.size() != 0); k++) begin
      bit w;
      w = wcount < 10 && sb.size() < DEPTH;
      cyc(1, w, 8'(8'h60 + wcount), wcount == 9, 1);
      if (w) wcount++;
    end
    chk("pkt38 complete", int'(sb.size() == 0 && wcount == 10), 1);
    chk("pkt38 pkt_cnt", int'(pkt_cnt[1]), 1);
    do_rst();
    cyc(0, 1, 8'h10, 0, 0);
    cyc(0, 1, 8'h11, 0, 0);
    do_rst();
    cyc(0, 1, 8'h5A, 1, 1);
    chk("post-rst tdata", int'(tdata[0]), 8'h5A);
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 0, 1);
    chk("post-rst pkt_cnt", int'(pkt_cnt[0]), 1);
    for (int m = 0; m < 2; m++) begin
      do_rst();
      for (int i = 0; i < 300; i++)
        cyc(m, bit'($urandom_range(1)), 8'($urandom), $urandom_range(3) == 0, $urandom_range(2) != 0);
      for (int i = 0; i < 12; i++) cyc(m, 0, 8'h00, 0, 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
